// File: rtl/load_arbiter.sv
// load_arbiter: round-robin arbiter granting 4 requesters one-cycle loads of a shared 4-bit register,
// followed by HOLD idle cycles and a done pulse.
module load_arbiter #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [3:0] data2,
  input  logic [3:0] data3,
  output logic [3:0] gnt,
  output logic       load,
  output logic [3:0] in,
  output logic [1:0] owner,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic       load_q, load_d;
  logic [3:0] in_q, in_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] w;
  logic [1:0] idx;
  logic       any;
  logic       grant;
  logic [3:0] dsel;
  // Scan from the farthest candidate down so the nearest one after last_q wins.
  always_comb begin
    w = last_q;
    any = 1'b0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_q + 2'(k + 1);
      if (req[idx]) begin
        w = idx;
        any = 1'b1;
      end
    end
    dsel = (w == 2'd0) ? data0 : (w == 2'd1) ? data1 : (w == 2'd2) ? data2 : data3;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = 4'b0000;
    load_d  = 1'b0;
    in_d    = in_q;
    owner_d = owner_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: grant = any;
      S_LOAD: begin
        if (HOLD == 0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
          cnt_d   = 4'(HOLD - 1);
          busy_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          grant   = any;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      state_d = S_LOAD;
      load_d  = 1'b1;
      busy_d  = 1'b1;
      gnt_d   = 4'b0001 << w;
      in_d    = dsel;
      owner_d = w;
      last_d  = w;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      load_q  <= 1'b0;
      in_q    <= 4'h0;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      in_q    <= in_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign gnt   = gnt_q;
  assign load  = load_q;
  assign in    = in_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_load_arbiter.sv
// tb_load_arbiter: directed checks of a HOLD=2 arbiter and a HOLD=0 arbiter sharing clock and reset.
module tb_load_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0, req0 = 4'h0;
  logic [3:0] data0 = 4'h2, data1 = 4'hA, data2 = 4'hC, data3 = 4'hF;
  logic [3:0] gnt, in, gnt0, in0;
  logic [1:0] owner, owner0;
  logic       load, busy, done, load0, busy0, done0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_arbiter #(.HOLD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .gnt(gnt), .load(load), .in(in), .owner(owner), .busy(busy), .done(done)
  );

  load_arbiter #(.HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .gnt(gnt0), .load(load0), .in(in0), .owner(owner0), .busy(busy0), .done(done0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 4'hF;
    #3;
    checks++; if ({load, gnt, in, owner, busy, done} !== 13'd0) begin errors++; $display("FAIL reset_outputs got %b exp %b", {load, gnt, in, owner, busy, done}, 13'd0); end
    step();
    step();
    checks++; if ({load, gnt, in, owner, busy, done} !== 13'd0) begin errors++; $display("FAIL reset_held got %b exp %b", {load, gnt, in, owner, busy, done}, 13'd0); end
    rst_n = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got %b exp %b", gnt, 4'b0001); end
    checks++; if (in !== 4'h2) begin errors++; $display("FAIL first_in got %h exp %h", in, 4'h2); end
    checks++; if ({load, busy, owner} !== 4'b1100) begin errors++; $display("FAIL first_load got %b exp %b", {load, busy, owner}, 4'b1100); end
  endtask

  task automatic test_round_robin();
    logic [3:0] ge [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] ie [4] = '{4'hA, 4'hC, 4'hF, 4'h2};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({load, gnt, busy} !== 6'b000001) begin errors++; $display("FAIL rr_hold_%0d got %b exp %b", i, {load, gnt, busy}, 6'b000001); end
      step();
      step();
      checks++; if (gnt !== ge[i]) begin errors++; $display("FAIL rr_gnt_%0d got %b exp %b", i, gnt, ge[i]); end
      checks++; if (in !== ie[i]) begin errors++; $display("FAIL rr_in_%0d got %h exp %h", i, in, ie[i]); end
      checks++; if ({load, done} !== 2'b11) begin errors++; $display("FAIL rr_load_done_%0d got %b exp %b", i, {load, done}, 2'b11); end
    end
    req = 4'h0;
    repeat (3) step();
    checks++; if ({load, busy, done} !== 3'b001) begin errors++; $display("FAIL rr_drain got %b exp %b", {load, busy, done}, 3'b001); end
  endtask

  task automatic test_single();
    req = 4'b0100;
    step();
    checks++; if ({load, gnt, in, owner} !== 11'b1_0100_1100_10) begin errors++; $display("FAIL single_grant got %b exp %b", {load, gnt, in, owner}, 11'b1_0100_1100_10); end
    req = 4'h0;
    step();
    step();
    checks++; if ({load, busy, done} !== 3'b010) begin errors++; $display("FAIL single_hold got %b exp %b", {load, busy, done}, 3'b010); end
    step();
    checks++; if ({load, busy, done} !== 3'b001) begin errors++; $display("FAIL single_done got %b exp %b", {load, busy, done}, 3'b001); end
    step();
    step();
    checks++; if ({load, gnt, busy, done} !== 7'd0) begin errors++; $display("FAIL single_idle got %b exp %b", {load, gnt, busy, done}, 7'd0); end
  endtask

  task automatic test_data_stability();
    req = 4'b0010;
    step();
    checks++; if ({gnt, in} !== 8'b0010_1010) begin errors++; $display("FAIL stab_grant got %b exp %b", {gnt, in}, 8'b0010_1010); end
    req = 4'h0;
    step();
    data1 = 4'h5;
    step();
    checks++; if (in !== 4'hA) begin errors++; $display("FAIL stab_hold got %h exp %h", in, 4'hA); end
    step();
    checks++; if (in !== 4'hA) begin errors++; $display("FAIL stab_done got %h exp %h", in, 4'hA); end
    req = 4'b0010;
    step();
    checks++; if ({load, in} !== 5'b1_0101) begin errors++; $display("FAIL stab_regrant got %b exp %b", {load, in}, 5'b1_0101); end
    req = 4'h0;
    data1 = 4'hA;
    repeat (3) step();
  endtask

  task automatic test_mid_reset();
    req = 4'b0101;
    step();
    checks++; if ({load, gnt} !== 5'b1_0100) begin errors++; $display("FAIL mrst_pre got %b exp %b", {load, gnt}, 5'b1_0100); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({load, gnt, busy, owner} !== 8'd0) begin errors++; $display("FAIL mrst_async got %b exp %b", {load, gnt, busy, owner}, 8'd0); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_no_done got %b exp %b", done, 1'b0); end
    rst_n = 1'b1;
    step();
    checks++; if ({load, gnt, in, done} !== 10'b1_0001_0010_0) begin errors++; $display("FAIL mrst_regrant got %b exp %b", {load, gnt, in, done}, 10'b1_0001_0010_0); end
    req = 4'h0;
    repeat (3) step();
  endtask

  task automatic test_back_to_back_hold0();
    req0 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({load0, gnt0, in0, done0} !== {1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010, (i % 2 == 0) ? 4'h2 : 4'hA, 1'b0}) begin errors++; $display("FAIL h0_load_%0d got %b exp gnt %b", i, {load0, gnt0, in0, done0}, (i % 2 == 0) ? 4'b0001 : 4'b0010); end
      step();
      checks++; if ({load0, gnt0, busy0, done0} !== 7'b0_0000_01) begin errors++; $display("FAIL h0_done_%0d got %b exp %b", i, {load0, gnt0, busy0, done0}, 7'b0_0000_01); end
    end
    req0 = 4'h0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_data_stability();
    test_mid_reset();
    test_back_to_back_hold0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
